wb_burst_master: RTL and testbench

- Pipelined Wishbone B4 initiator, 32-bit data, word-addressed. Drives the bus side consumed by `wb_mem` and other register/memory responders.
- Accepts one burst command at a time (start address, beat count, direction, byte select).
- Streams write data in and read data out.
- Issues up to MAX_OUTSTANDING requests ahead of acknowledgements. Holds CYC for the whole burst.

---
 rtl/wb_burst_master_if.sv | 24 ++
 rtl/wb_burst_master.sv | 210 +++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_master_if.sv
// Wishbone B4 pipelined bus bundle between the burst initiator and a responder.
interface wb_burst_master_if #(
    parameter int ADDR_WIDTH = 6
) ();
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           dat_w;
    logic [3:0]            sel;
    logic                  stall;
    logic                  ack;
    logic [31:0]           dat_r;

    modport master (
        output cyc, stb, we, addr, dat_w, sel,
        input  stall, ack, dat_r
    );

    modport slave (
        input  cyc, stb, we, addr, dat_w, sel,
        output stall, ack, dat_r
    );
endinterface

// File: rtl/wb_burst_master.sv
// Pipelined Wishbone B4 burst initiator: takes one burst command at a time,
// keeps CYC asserted for the whole burst and pipelines requests ahead of
// acknowledgements up to a fixed outstanding limit.
module wb_burst_master #(
    parameter int WB_ADDR_WIDTH   = 6,
    parameter int LEN_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [LEN_WIDTH-1:0]     i_cmd_len,
    input  logic [3:0]               i_cmd_sel,
    input  logic [31:0]              i_wdata,
    input  logic                     i_wdata_valid,
    output logic                     o_wdata_ready,
    output logic [31:0]              o_rdata,
    output logic                     o_rdata_valid,
    output logic                     o_busy,
    output logic                     o_done,
    wb_burst_master_if.master        wb
);

    localparam int CNT_W = LEN_WIDTH + 1;
    // One spare bit so the +1/-1 outstanding arithmetic can never wrap.
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1) + 1;
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        ST_IDLE,
        ST_BUS
    } state_e;

    state_e                   state_q, state_d;
    logic                     we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [3:0]               sel_q, sel_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     cyc_q, cyc_d;
    logic                     stb_q, stb_d;
    logic                     bus_we_q, bus_we_d;
    logic [WB_ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]              bus_data_q, bus_data_d;
    logic [3:0]               bus_sel_q, bus_sel_d;
    logic [CNT_W-1:0]         issued_q, issued_d;
    logic [CNT_W-1:0]         loaded_q, loaded_d;
    logic [OUT_W-1:0]         outstanding_q, outstanding_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     rdata_valid_q, rdata_valid_d;

    logic                     in_bus;
    logic                     req_accept;
    logic                     ack_ok;
    logic [OUT_W-1:0]         outstanding_next;
    logic [CNT_W-1:0]         beats_total;
    logic                     load_ok;
    logic                     load;
    logic                     finish;

    // Per-cycle bus events and the beat-load decision; a write beat's data
    // handshake is the load itself, so ready never depends on valid.
    always_comb begin
        in_bus           = (state_q == ST_BUS);
        req_accept       = in_bus && stb_q && !wb.stall;
        ack_ok           = in_bus && wb.ack && (outstanding_q != '0);
        outstanding_next = outstanding_q + {{(OUT_W-1){1'b0}}, req_accept}
                                         - {{(OUT_W-1){1'b0}}, ack_ok};
        beats_total      = {1'b0, len_q} + CNT_W'(1);
        load_ok          = in_bus && (loaded_q < beats_total)
                           && (!stb_q || req_accept)
                           && (outstanding_next < OUT_MAX);
        load             = load_ok && (!we_q || i_wdata_valid);
        finish           = ack_ok && (outstanding_next == '0)
                           && (issued_q == beats_total);
    end

    // Next-state and register updates for the two-state burst controller.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        start_addr_d  = start_addr_q;
        len_d         = len_q;
        sel_d         = sel_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        cyc_d         = 1'b0;
        stb_d         = stb_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_data_d    = bus_data_q;
        bus_sel_d     = bus_sel_q;
        issued_d      = issued_q;
        loaded_d      = loaded_q;
        outstanding_d = outstanding_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    state_d       = ST_BUS;
                    we_d          = i_cmd_we;
                    start_addr_d  = i_cmd_addr;
                    len_d         = i_cmd_len;
                    sel_d         = i_cmd_sel;
                    busy_d        = 1'b1;
                    issued_d      = '0;
                    loaded_d      = '0;
                    outstanding_d = '0;
                    bus_data_d    = '0;
                end
            end
            ST_BUS: begin
                cyc_d         = 1'b1;
                outstanding_d = outstanding_next;
                if (req_accept) begin
                    issued_d = issued_q + CNT_W'(1);
                end
                if (load) begin
                    stb_d      = 1'b1;
                    bus_addr_d = start_addr_q + WB_ADDR_WIDTH'(loaded_q);
                    bus_data_d = we_q ? i_wdata : 32'h0;
                    bus_we_d   = we_q;
                    bus_sel_d  = sel_q;
                    loaded_d   = loaded_q + CNT_W'(1);
                end else if (req_accept) begin
                    stb_d = 1'b0;
                end
                if (ack_ok && !we_q) begin
                    rdata_d       = wb.dat_r;
                    rdata_valid_d = 1'b1;
                end
                if (finish) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            we_q          <= 1'b0;
            start_addr_q  <= '0;
            len_q         <= '0;
            sel_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_data_q    <= '0;
            bus_sel_q     <= '0;
            issued_q      <= '0;
            loaded_q      <= '0;
            outstanding_q <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            start_addr_q  <= start_addr_d;
            len_q         <= len_d;
            sel_q         <= sel_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_data_q    <= bus_data_d;
            bus_sel_q     <= bus_sel_d;
            issued_q      <= issued_d;
            loaded_q      <= loaded_d;
            outstanding_q <= outstanding_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    // Output mapping: bus and status outputs come straight from registers.
    always_comb begin
        o_cmd_ready   = (state_q == ST_IDLE);
        o_wdata_ready = load_ok && we_q;
        o_rdata       = rdata_q;
        o_rdata_valid = rdata_valid_q;
        o_busy        = busy_q;
        o_done        = done_q;
        wb.cyc        = cyc_q;
        wb.stb        = stb_q;
        wb.we         = bus_we_q;
        wb.addr       = bus_addr_q;
        wb.dat_w      = bus_data_q;
        wb.sel        = bus_sel_q;
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master against a small Wishbone memory
// responder with runtime-adjustable stall and ack latency.
module tb_wb_burst_master;

    localparam int AW = 6;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_we;
    logic [AW-1:0] i_cmd_addr;
    logic [LW-1:0] i_cmd_len;
    logic [3:0]    i_cmd_sel;
    logic [31:0]   i_wdata;
    logic          i_wdata_valid;
    logic          o_wdata_ready;
    logic [31:0]   o_rdata;
    logic          o_rdata_valid;
    logic          o_busy;
    logic          o_done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] wr_data [0:15];

    always #5 clk = ~clk;

    wb_burst_master_if #(.ADDR_WIDTH(AW)) wb ();

    wb_burst_master #(
        .WB_ADDR_WIDTH  (AW),
        .LEN_WIDTH      (LW),
        .MAX_OUTSTANDING(2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_we     (i_cmd_we),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_len    (i_cmd_len),
        .i_cmd_sel    (i_cmd_sel),
        .i_wdata      (i_wdata),
        .i_wdata_valid(i_wdata_valid),
        .o_wdata_ready(o_wdata_ready),
        .o_rdata      (o_rdata),
        .o_rdata_valid(o_rdata_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .wb           (wb)
    );

    // ---------------- responder: memory with stall/ack wait states ----------
    int          stall_ws = 0;
    int          ack_ws   = 0;
    int          stall_cnt;
    logic        mem_ready = 1'b0;
    logic [31:0] mem    [0:63];
    logic        pipe_v [0:7];
    logic [31:0] pipe_d [0:7];

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    assign wb.stall = wb.cyc && wb.stb && (stall_cnt < stall_ws);
    assign wb.ack   = pipe_v[0];
    assign wb.dat_r = pipe_d[0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 0;
            for (int i = 0; i < 8; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= 32'h0;
            end
            if (!mem_ready) begin
                for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
                mem_ready <= 1'b1;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                pipe_v[i] <= pipe_v[i+1];
                pipe_d[i] <= pipe_d[i+1];
            end
            pipe_v[7] <= 1'b0;
            pipe_d[7] <= 32'h0;
            if (wb.cyc && wb.stb && !wb.stall) begin
                stall_cnt      <= 0;
                pipe_v[ack_ws] <= 1'b1;
                pipe_d[ack_ws] <= wb.we ? 32'h0 : mem[wb.addr];
                if (wb.we) mem[wb.addr] <= merge(mem[wb.addr], wb.dat_w, wb.sel);
            end else if (wb.cyc && wb.stb) begin
                stall_cnt <= stall_cnt + 1;
            end
        end
    end

    // ---------------- bus monitor, sampled on the falling edge --------------
    int          rel, mon_total;
    int          stb_cnt, cyc_cnt, acc_cnt, rd_cnt, done_cnt, wd_hs, ack_cnt;
    int          first_stb, last_stb, first_ack, first_rv, done_rel;
    int          out_cnt, max_out, stb_low_at_max, hold_err, gap_cnt, busy_err, wdat_nz;
    logic [AW-1:0] acc_addr [0:15];
    logic [31:0] acc_data [0:15];
    logic [31:0] rd_data  [0:15];
    logic        prev_hold;
    logic [AW-1:0] prev_addr;
    logic [31:0] prev_dat;
    logic [3:0]  prev_sel;
    logic        prev_we;
    logic        mon_acc, mon_ack;
    int          out_new;

    assign mon_acc = wb.cyc && wb.stb && !wb.stall;
    assign mon_ack = wb.cyc && wb.ack && (out_cnt > 0);
    assign out_new = out_cnt + (mon_acc ? 1 : 0) - (mon_ack ? 1 : 0);

    always @(negedge clk) begin
        if (rst_n && i_cmd_valid && o_cmd_ready) begin
            rel <= -1; mon_total <= int'(i_cmd_len) + 1;
            stb_cnt <= 0; cyc_cnt <= 0; acc_cnt <= 0; rd_cnt <= 0; done_cnt <= 0;
            wd_hs <= 0; ack_cnt <= 0; first_stb <= -1; last_stb <= -1;
            first_ack <= -1; first_rv <= -1; done_rel <= -1; max_out <= 0;
            stb_low_at_max <= 0; hold_err <= 0; gap_cnt <= 0; busy_err <= 0; wdat_nz <= 0;
        end else begin
            rel <= rel + 1;
            if (wb.stb) begin
                stb_cnt <= stb_cnt + 1;
                last_stb <= rel + 1;
                if (first_stb < 0) first_stb <= rel + 1;
            end
            if (wb.cyc) cyc_cnt <= cyc_cnt + 1;
            if (mon_acc) begin
                if (acc_cnt < 16) begin
                    acc_addr[acc_cnt] <= wb.addr;
                    acc_data[acc_cnt] <= wb.dat_w;
                end
                acc_cnt <= acc_cnt + 1;
            end
            if (wb.cyc && wb.ack) begin
                ack_cnt <= ack_cnt + 1;
                if (first_ack < 0) first_ack <= rel + 1;
            end
            if (o_rdata_valid) begin
                if (rd_cnt < 16) rd_data[rd_cnt] <= o_rdata;
                rd_cnt <= rd_cnt + 1;
                if (first_rv < 0) first_rv <= rel + 1;
            end
            if (o_done) begin
                done_cnt <= done_cnt + 1;
                done_rel <= rel + 1;
            end
            if (i_wdata_valid && o_wdata_ready) wd_hs <= wd_hs + 1;
            if (out_new > max_out) max_out <= out_new;
            if (wb.cyc && !wb.stb && out_cnt == 2) stb_low_at_max <= stb_low_at_max + 1;
            if (prev_hold && !(wb.stb && wb.addr == prev_addr && wb.dat_w == prev_dat &&
                               wb.sel == prev_sel && wb.we == prev_we))
                hold_err <= hold_err + 1;
            if (wb.cyc && !wb.stb && o_busy && first_stb >= 0 && acc_cnt < mon_total)
                gap_cnt <= gap_cnt + 1;
            if (wb.cyc && !o_busy) busy_err <= busy_err + 1;
            if (wb.stb && !wb.we && wb.dat_w != 32'h0) wdat_nz <= wdat_nz + 1;
        end
        out_cnt   <= rst_n ? out_new : 0;
        prev_hold <= wb.stb && wb.stall;
        prev_addr <= wb.addr;
        prev_dat  <= wb.dat_w;
        prev_sel  <= wb.sel;
        prev_we   <= wb.we;
    end

    // ---------------- checking and stimulus tasks ---------------------------
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issueCommand(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        logic seen;
        seen = 1'b0;
        i_cmd_we = we; i_cmd_addr = addr; i_cmd_len = len; i_cmd_sel = 4'hF;
        i_cmd_valid = 1'b1;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            seen = o_cmd_ready;
            @(posedge clk); #1;
        end
        i_cmd_valid = 1'b0;
        if (!seen) checkOutput("cmd_accept_timeout", 32'(seen), 32'd1);
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                                 input int gap_after, input int gap_len);
        logic got;
        issueCommand(we, addr, len);
        if (we) begin
            for (int k = 0; k <= int'(len); k++) begin
                i_wdata = wr_data[k];
                i_wdata_valid = 1'b1;
                got = 1'b0;
                for (int t = 0; t < 200 && !got; t++) begin
                    @(negedge clk);
                    got = i_wdata_valid && o_wdata_ready;
                    @(posedge clk); #1;
                end
                if (!got) begin
                    checkOutput("wdata_hs_timeout", 32'(got), 32'd1);
                    break;
                end
                if (k == gap_after) begin
                    i_wdata_valid = 1'b0;
                    repeat (gap_len) begin @(posedge clk); #1; end
                end
            end
            i_wdata_valid = 1'b0;
        end
        for (int t = 0; t < 1000 && done_cnt == 0; t++) begin
            @(posedge clk); #1;
        end
        checkOutput("done_seen", 32'(done_cnt), 32'd1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // ---------------- directed test sequence --------------------------------
    initial begin
        int rd_before;
        rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = '0;
        i_cmd_len = '0; i_cmd_sel = '0; i_wdata = '0; i_wdata_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        checkOutput("reset_flags", 32'({o_cmd_ready, o_busy, o_done, wb.cyc, wb.stb, wb.we,
                                         o_rdata_valid, o_wdata_ready}), 32'h80);
        checkOutput("reset_rdata", o_rdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] single write then read");
        wr_data[0] = 32'hAABBCCDD;
        applyStimulus(1'b1, 6'd15, 8'd0, -1, 0);
        checkOutput("t1_stb_cycles", 32'(stb_cnt), 32'd1);
        checkOutput("t1_cyc_cycles", 32'(cyc_cnt), 32'd2);
        checkOutput("t1_wdata_hs", 32'(wd_hs), 32'd1);
        checkOutput("t1_addr", 32'(acc_addr[0]), 32'd15);
        checkOutput("t1_data", acc_data[0], 32'hAABBCCDD);
        checkOutput("t1_first_stb", 32'(first_stb), 32'd1);
        checkOutput("t1_done_rel", 32'(done_rel), 32'd3);
        applyStimulus(1'b0, 6'd15, 8'd0, -1, 0);
        checkOutput("t1_rdata", rd_data[0], 32'hAABBCCDD);
        checkOutput("t1_rd_cnt", 32'(rd_cnt), 32'd1);
        checkOutput("t1_first_ack", 32'(first_ack), 32'd2);
        checkOutput("t1_first_rv", 32'(first_rv), 32'd3);
        checkOutput("t1_rd_done_rel", 32'(done_rel), 32'd3);
        checkOutput("t1_rd_wdat_zero", 32'(wdat_nz), 32'd0);

        $display("[TB] wrap-around burst");
        for (int i = 0; i < 4; i++) wr_data[i] = 32'd10 + i;
        applyStimulus(1'b1, 6'd62, 8'd3, -1, 0);
        checkOutput("t2_addr0", 32'(acc_addr[0]), 32'd62);
        checkOutput("t2_addr1", 32'(acc_addr[1]), 32'd63);
        checkOutput("t2_addr2", 32'(acc_addr[2]), 32'd0);
        checkOutput("t2_addr3", 32'(acc_addr[3]), 32'd1);
        applyStimulus(1'b0, 6'd62, 8'd3, -1, 0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t2_rdata%0d", i), rd_data[i], 32'd10 + i);
        checkOutput("t2_stb_cycles", 32'(stb_cnt), 32'd4);
        checkOutput("t2_stb_span", 32'({first_stb[7:0], last_stb[7:0]}), 32'h0104);
        checkOutput("t2_cyc_cycles", 32'(cyc_cnt), 32'd5);
        checkOutput("t2_done_rel", 32'(done_rel), 32'd6);

        $display("[TB] stalled write burst");
        stall_ws = 2;
        for (int i = 0; i < 4; i++) wr_data[i] = 32'h30 + i;
        applyStimulus(1'b1, 6'd40, 8'd3, -1, 0);
        checkOutput("t3_acc_cnt", 32'(acc_cnt), 32'd4);
        checkOutput("t3_stb_cycles", 32'(stb_cnt), 32'd12);
        checkOutput("t3_hold_err", 32'(hold_err), 32'd0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t3_addr%0d", i), 32'(acc_addr[i]), 32'd40 + i);
        stall_ws = 0;
        applyStimulus(1'b0, 6'd40, 8'd3, -1, 0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t3_rdata%0d", i), rd_data[i], 32'h30 + i);

        $display("[TB] outstanding limit");
        ack_ws = 3;
        applyStimulus(1'b0, 6'd4, 8'd7, -1, 0);
        checkOutput("t4_max_out", 32'(max_out), 32'd2);
        checkOutput("t4_stb_low_at_max", 32'(stb_low_at_max > 0), 32'd1);
        checkOutput("t4_rd_cnt", 32'(rd_cnt), 32'd8);
        checkOutput("t4_done_cnt", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("t4_rdata%0d", i), rd_data[i], 32'h1000_0004 + i);
        ack_ws = 0;

        $display("[TB] write data starvation");
        for (int i = 0; i < 4; i++) wr_data[i] = 32'h50 + i;
        applyStimulus(1'b1, 6'd20, 8'd3, 1, 3);
        checkOutput("t5_gap_cycles", 32'(gap_cnt), 32'd3);
        checkOutput("t5_busy_err", 32'(busy_err), 32'd0);
        checkOutput("t5_cyc_cycles", 32'(cyc_cnt), 32'd8);
        checkOutput("t5_acc_cnt", 32'(acc_cnt), 32'd4);
        checkOutput("t5_wdata_hs", 32'(wd_hs), 32'd4);
        applyStimulus(1'b0, 6'd20, 8'd3, -1, 0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t5_rdata%0d", i), rd_data[i], 32'h50 + i);

        $display("[TB] reset mid-burst");
        ack_ws = 1;
        issueCommand(1'b0, 6'd4, 8'd7);
        for (int t = 0; t < 200 && ack_cnt < 2; t++) begin
            @(posedge clk); #1;
        end
        checkOutput("t6_two_acks", 32'(ack_cnt >= 2), 32'd1);
        rd_before = rd_cnt;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_drop", 32'({wb.cyc, wb.stb, o_busy}), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("t6_no_more_rdata", 32'(rd_cnt), 32'(rd_before));
        checkOutput("t6_cmd_ready", 32'(o_cmd_ready), 32'd1);
        ack_ws = 0;
        applyStimulus(1'b0, 6'd15, 8'd0, -1, 0);
        checkOutput("t6_rdata", rd_data[0], 32'hAABBCCDD);
        checkOutput("t6_rd_cnt", 32'(rd_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
